// File: rtl/json_str_escaper_if.sv
// rtl/json_str_escaper_if.sv - raw-byte input and escaped-char output handshakes for json_str_escaper
interface json_str_escaper_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    // escaper side: consumes raw bytes, produces escaped characters
    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    // source/sink side
    modport master (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/json_str_escaper.sv
// rtl/json_str_escaper.sv - raw byte to JSON-escaped character stream; optional quoting via JSON_STR_ESCAPER_QUOTE_EN
module json_str_escaper #(
    parameter int HEX_UPPER = 0,
    parameter int ESC_HIGH  = 1
) (
    input  logic                clk_ip,
    input  logic                rst_ip,
    json_str_escaper_if.slave   bus,
    output logic                busy
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_OPENQ, S_CLOSEQ} state_t;
    typedef enum logic [1:0] {C_PLAIN, C_SHORT, C_UNI} cls_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_byte;
    cls_t        r_cls;
    logic        r_last;
    logic [2:0]  r_idx;
    logic [2:0]  w_len_m1;
    logic        w_at_end;
    logic        w_accept;
    logic        w_in_ready;
    logic [7:0]  w_char;
`ifdef JSON_STR_ESCAPER_QUOTE_EN
    logic        r_first;
`endif

    // Expansion class of a raw byte: 1, 2 or 6 output characters
    function automatic cls_t classify(input logic [7:0] b);
        if (b == 8'h22 || b == 8'h5C || b == 8'h08 || b == 8'h0C ||
            b == 8'h0A || b == 8'h0D || b == 8'h09)
            return C_SHORT;
        else if (b < 8'h20)
            return C_UNI;
        else if (b >= 8'h7F && ESC_HIGH != 0)
            return C_UNI;
        else
            return C_PLAIN;
    endfunction

    // Second character of a two-character escape
    function automatic logic [7:0] short_char(input logic [7:0] b);
        case (b)
            8'h08:   return 8'h62;
            8'h0C:   return 8'h66;
            8'h0A:   return 8'h6E;
            8'h0D:   return 8'h72;
            8'h09:   return 8'h74;
            default: return b;
        endcase
    endfunction

    // ASCII hex digit for one nibble; 0x37/0x57 are 'A'-10 and 'a'-10
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else if (HEX_UPPER != 0)
            return 8'h37 + {4'h0, n};
        else
            return 8'h57 + {4'h0, n};
    endfunction

    always_comb begin
        case (r_cls)
            C_SHORT: w_len_m1 = 3'd1;
            C_UNI:   w_len_m1 = 3'd5;
            default: w_len_m1 = 3'd0;
        endcase
    end

    assign w_at_end = (r_idx == w_len_m1);

    // A new byte may only be taken when nothing is showing or the final char is leaving now;
    // with quoting, the end of a string must first make room for the closing quote.
`ifdef JSON_STR_ESCAPER_QUOTE_EN
    assign w_in_ready = (r_state == S_IDLE) ||
                        (r_state == S_EMIT && bus.out_ready && w_at_end && !r_last);
`else
    assign w_in_ready = (r_state == S_IDLE) ||
                        (r_state == S_EMIT && bus.out_ready && w_at_end);
`endif

    assign bus.in_ready = w_in_ready;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign busy         = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk_ip or negedge rst_ip) begin
        if (!rst_ip)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_EMIT;
`ifdef JSON_STR_ESCAPER_QUOTE_EN
                    if (r_first)
                        w_next = S_OPENQ;
`endif
                end
            end
            S_OPENQ: begin
                if (bus.out_ready)
                    w_next = S_EMIT;
            end
            S_EMIT: begin
                if (bus.out_ready && w_at_end) begin
                    if (w_accept)
                        w_next = S_EMIT;
                    else
                        w_next = S_IDLE;
`ifdef JSON_STR_ESCAPER_QUOTE_EN
                    if (r_last)
                        w_next = S_CLOSEQ;
`endif
                end
            end
            S_CLOSEQ: begin
                if (bus.out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the byte and its class on accept; step idx as characters are taken
    always_ff @(posedge clk_ip or negedge rst_ip) begin
        if (!rst_ip) begin
            r_byte  <= 8'h00;
            r_cls   <= C_PLAIN;
            r_last  <= 1'b0;
            r_idx   <= 3'd0;
`ifdef JSON_STR_ESCAPER_QUOTE_EN
            r_first <= 1'b1;
`endif
        end else if (w_accept) begin
            r_byte  <= bus.in_data;
            r_cls   <= classify(bus.in_data);
            r_last  <= bus.in_last;
            r_idx   <= 3'd0;
`ifdef JSON_STR_ESCAPER_QUOTE_EN
            r_first <= bus.in_last;
`endif
        end else if (r_state == S_EMIT && bus.out_ready && !w_at_end) begin
            r_idx   <= r_idx + 3'd1;
        end
    end

    // Character at position idx of the current byte's expansion
    always_comb begin
        w_char = r_byte;
        case (r_cls)
            C_SHORT: w_char = (r_idx == 3'd0) ? 8'h5C : short_char(r_byte);
            C_UNI: begin
                case (r_idx)
                    3'd0:    w_char = 8'h5C;
                    3'd1:    w_char = 8'h75;
                    3'd2:    w_char = 8'h30;
                    3'd3:    w_char = 8'h30;
                    3'd4:    w_char = hex_char(r_byte[7:4]);
                    default: w_char = hex_char(r_byte[3:0]);
                endcase
            end
            default: w_char = r_byte;
        endcase
    end

    // Output decode from state; everything is quiet in IDLE
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        bus.out_last  = 1'b0;
        case (r_state)
            S_EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = w_char;
`ifdef JSON_STR_ESCAPER_QUOTE_EN
                bus.out_last  = 1'b0;
`else
                bus.out_last  = r_last && w_at_end;
`endif
            end
            S_OPENQ: begin
                bus.out_valid = 1'b1;
                bus.out_data  = 8'h22;
            end
            S_CLOSEQ: begin
                bus.out_valid = 1'b1;
                bus.out_data  = 8'h22;
                bus.out_last  = 1'b1;
            end
            default: begin
                bus.out_valid = 1'b0;
            end
        endcase
    end

endmodule
